key_scan_ctrl: RTL and testbench

Sequential front end for the 10-key active-low keypad. It synchronises and debounces the raw key lines S_n, priority-encodes the pressed key (key 9 highest, key 0 lowest) into 8421 BCD, and delivers one code per debounced press to a downstream consumer over a valid/ready handshake. It also maintains a debounced "key held" flag. The block sits between the keypad pins and the display/command logic.

---
 rtl/key_scan_if.sv | 21 ++
 rtl/key_scan_ctrl.sv | 168 ++++++++++++++++
 tb/tb_key_scan_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_scan_if.sv
// Key code delivery bus: valid/ready handshake carrying a BCD key code plus the held flag.
interface key_scan_if;
    logic [3:0] code;
    logic       valid;
    logic       ready;
    logic       GS;

    modport master (
        output code,
        output valid,
        output GS,
        input  ready
    );

    modport slave (
        input  code,
        input  valid,
        input  GS,
        output ready
    );
endinterface

// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl: synchronises and debounces a 10-key active-low keypad, priority
// encodes the pressed key (key 9 wins) into BCD and hands one code per press to
// the consumer over valid/ready. Optional feature macro: KEY_REPEAT_EN enables
// auto-repeat of a held key every REPEAT_CYCLES cycles.
module key_scan_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_CYCLES   = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [9:0]      S_n,
    key_scan_if.master      bus
);

    localparam int unsigned CNT_MAX_VAL = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ?
                                          DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CNT_W       = $clog2(CNT_MAX_VAL + 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        OUT,
        HOLD,
        REL_DB
    } state_t;

    logic [9:0]       s_meta;
    logic [9:0]       s;
    logic             any;
    logic [3:0]       enc;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             gs_q, gs_d;

    // Two-flop synchroniser for the asynchronous key lines; idle value is all released.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_meta <= 10'h3FF;
            s      <= 10'h3FF;
        end else begin
            s_meta <= S_n;
            s      <= s_meta;
        end
    end

    // Priority encoder: ascending scan so the highest-numbered pressed key wins.
    always_comb begin
        enc = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (!s[i]) begin
                enc = 4'(i);
            end
        end
    end

    assign any     = ~&s;
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state and next-output logic for the debounce / handshake FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = code_q;

        unique case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = PRESS_DB;
                    cand_d  = enc;
                    cnt_d   = '0;
                end
            end

            PRESS_DB: begin
                if (!any) begin
                    state_d = IDLE;
                end else if (enc != cand_q) begin
                    cand_d = enc;
                    cnt_d  = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = OUT;
                    code_d  = cand_q;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            // A pending code survives key release; only the consumer retires it.
            OUT: begin
                if (bus.ready) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end

            // Other keys pressed while held are ignored until a full release.
            HOLD: begin
                if (!any) begin
                    state_d = REL_DB;
                    cnt_d   = '0;
                end
`ifdef KEY_REPEAT_EN
                else if (cnt_q == RPT_LAST) begin
                    state_d = OUT;
                    code_d  = cand_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end

            REL_DB: begin
                if (any) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        valid_d = (state_d == OUT);
        gs_d    = (state_d == OUT) || (state_d == HOLD) || (state_d == REL_DB);
    end

    // State, counter and registered outputs; reset discards any pending code.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= 4'd0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            gs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            gs_q    <= gs_d;
        end
    end

    assign bus.code  = code_q;
    assign bus.valid = valid_q;
    assign bus.GS    = gs_q;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Directed testbench for key_scan_ctrl with DEBOUNCE_CYCLES = 4, REPEAT_CYCLES = 8.
module tb_key_scan_ctrl;

    logic       clk;
    logic       rst;
    logic [9:0] S_n;

    int errors;
    int checks;
    int xfer;

    key_scan_if bus ();

    key_scan_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_CYCLES  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .S_n (S_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completed transfers as seen at the rising edge.
    always @(posedge clk) begin
        if (!rst && bus.valid && bus.ready) begin
            xfer <= xfer + 1;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int seen_valid;
        int seen_gs;
        rst = 1'b1;
        S_n = 10'h3FF;
        bus.ready = 1'b1;
        tick(3);
        checks++;
        if (bus.code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", bus.code); end
        checks++;
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
        checks++;
        if (bus.GS !== 1'b0) begin errors++; $display("FAIL reset_gs: got %b expected 0", bus.GS); end
        rst = 1'b0;
        seen_valid = 0;
        seen_gs = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.valid !== 1'b0) seen_valid++;
            if (bus.GS !== 1'b0) seen_gs++;
        end
        checks++;
        if (seen_valid !== 0) begin errors++; $display("FAIL idle_valid: got %0d cycles high expected 0", seen_valid); end
        checks++;
        if (seen_gs !== 0) begin errors++; $display("FAIL idle_gs: got %0d cycles high expected 0", seen_gs); end
    endtask

    task automatic test_single_press();
        int x0;
        x0 = xfer;
        S_n = 10'b11_1101_1111;
        tick(6);
        checks++;
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL press_early_valid: got %b expected 0", bus.valid); end
        tick(1);
        checks++;
        if (bus.valid !== 1'b1) begin errors++; $display("FAIL press_valid: got %b expected 1", bus.valid); end
        checks++;
        if (bus.code !== 4'd5) begin errors++; $display("FAIL press_code: got %0d expected 5", bus.code); end
        checks++;
        if (bus.GS !== 1'b1) begin errors++; $display("FAIL press_gs: got %b expected 1", bus.GS); end
        tick(1);
        checks++;
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL press_pulse_len: got %b expected 0", bus.valid); end
        checks++;
        if (xfer !== x0 + 1) begin errors++; $display("FAIL press_xfer: got %0d expected %0d", xfer, x0 + 1); end
        S_n = 10'h3FF;
        tick(6);
        checks++;
        if (bus.GS !== 1'b1) begin errors++; $display("FAIL release_early_gs: got %b expected 1", bus.GS); end
        tick(1);
        checks++;
        if (bus.GS !== 1'b0) begin errors++; $display("FAIL release_gs: got %b expected 0", bus.GS); end
        tick(3);
    endtask

    task automatic test_priority();
        S_n = 10'b01_1111_1110;
        tick(7);
        checks++;
        if (bus.valid !== 1'b1 || bus.code !== 4'd9) begin
            errors++; $display("FAIL prio_9_0: got valid=%b code=%0d expected valid=1 code=9", bus.valid, bus.code);
        end
        tick(1);
        S_n = 10'h3FF;
        tick(10);
        S_n = 10'h3FE;
        tick(7);
        checks++;
        if (bus.valid !== 1'b1 || bus.code !== 4'd0) begin
            errors++; $display("FAIL key0: got valid=%b code=%0d expected valid=1 code=0", bus.valid, bus.code);
        end
        checks++;
        if (bus.GS !== 1'b1) begin errors++; $display("FAIL key0_gs: got %b expected 1", bus.GS); end
        tick(1);
        S_n = 10'h3FF;
        tick(10);
    endtask

    task automatic test_bounce();
        int x0;
        int seen_valid;
        int seen_gs;
        int gs_low;
        x0 = xfer;
        seen_valid = 0;
        seen_gs = 0;
        S_n = 10'h3F7;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (bus.valid !== 1'b0) seen_valid++;
            if (bus.GS !== 1'b0) seen_gs++;
        end
        S_n = 10'h3FF;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.valid !== 1'b0) seen_valid++;
            if (bus.GS !== 1'b0) seen_gs++;
        end
        checks++;
        if (seen_valid !== 0) begin errors++; $display("FAIL bounce_valid: got %0d cycles high expected 0", seen_valid); end
        checks++;
        if (seen_gs !== 0) begin errors++; $display("FAIL bounce_gs: got %0d cycles high expected 0", seen_gs); end
        checks++;
        if (xfer !== x0) begin errors++; $display("FAIL bounce_xfer: got %0d expected %0d", xfer, x0); end

        // Release glitch: REL_DB must fall back to HOLD and restart the release count.
        S_n = 10'h3FD;
        tick(8);
        x0 = xfer;
        gs_low = 0;
        S_n = 10'h3FF;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (bus.GS !== 1'b1) gs_low++;
        end
        S_n = 10'h3FD;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            if (bus.GS !== 1'b1) gs_low++;
        end
        S_n = 10'h3FF;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (bus.GS !== 1'b1) gs_low++;
        end
        checks++;
        if (gs_low !== 0) begin errors++; $display("FAIL glitch_gs_held: got %0d cycles low expected 0", gs_low); end
        tick(1);
        checks++;
        if (bus.GS !== 1'b0) begin errors++; $display("FAIL glitch_release_gs: got %b expected 0", bus.GS); end
        checks++;
        if (xfer !== x0) begin errors++; $display("FAIL glitch_xfer: got %0d expected %0d", xfer, x0); end
        tick(3);
    endtask

    task automatic test_back_pressure();
        int x0;
        x0 = xfer;
        bus.ready = 1'b0;
        S_n = 10'h37F;
        tick(7);
        checks++;
        if (bus.valid !== 1'b1 || bus.code !== 4'd7) begin
            errors++; $display("FAIL bp_first: got valid=%b code=%0d expected valid=1 code=7", bus.valid, bus.code);
        end
        S_n = 10'h3FF;
        tick(10);
        checks++;
        if (bus.valid !== 1'b1 || bus.code !== 4'd7) begin
            errors++; $display("FAIL bp_held: got valid=%b code=%0d expected valid=1 code=7", bus.valid, bus.code);
        end
        checks++;
        if (xfer !== x0) begin errors++; $display("FAIL bp_no_xfer: got %0d expected %0d", xfer, x0); end
        bus.ready = 1'b1;
        tick(1);
        checks++;
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL bp_clear: got %b expected 0", bus.valid); end
        tick(8);
        checks++;
        if (xfer !== x0 + 1) begin errors++; $display("FAIL bp_one_xfer: got %0d expected %0d", xfer, x0 + 1); end
        checks++;
        if (bus.GS !== 1'b0) begin errors++; $display("FAIL bp_gs: got %b expected 0", bus.GS); end
        S_n = 10'h3FB;
        tick(7);
        checks++;
        if (bus.valid !== 1'b1 || bus.code !== 4'd2) begin
            errors++; $display("FAIL bp_next: got valid=%b code=%0d expected valid=1 code=2", bus.valid, bus.code);
        end
        tick(1);
        S_n = 10'h3FF;
        tick(10);
    endtask

    task automatic test_mid_reset();
        int seen_valid;
        bus.ready = 1'b0;
        S_n = 10'h3BF;
        tick(7);
        checks++;
        if (bus.valid !== 1'b1 || bus.code !== 4'd6) begin
            errors++; $display("FAIL mid_pending: got valid=%b code=%0d expected valid=1 code=6", bus.valid, bus.code);
        end
        rst = 1'b1;
        S_n = 10'h3FF;
        tick(1);
        checks++;
        if (bus.valid !== 1'b0 || bus.GS !== 1'b0 || bus.code !== 4'd0) begin
            errors++; $display("FAIL mid_reset: got valid=%b gs=%b code=%0d expected 0 0 0", bus.valid, bus.GS, bus.code);
        end
        rst = 1'b0;
        bus.ready = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.valid !== 1'b0) seen_valid++;
        end
        checks++;
        if (seen_valid !== 0) begin errors++; $display("FAIL mid_discard: got %0d cycles valid expected 0", seen_valid); end
    endtask

    task automatic test_repeat();
        int hits;
        int exp_t;
        int exp_hits;
`ifdef KEY_REPEAT_EN
        exp_hits = 4;
`else
        exp_hits = 1;
`endif
        hits = 0;
        exp_t = 7;
        bus.ready = 1'b1;
        S_n = 10'h3EF;
        for (int t = 1; t <= 40; t++) begin
            tick(1);
            if (bus.valid === 1'b1) begin
                checks++;
                if (t !== exp_t || bus.code !== 4'd4) begin
                    errors++; $display("FAIL repeat_code: got tick=%0d code=%0d expected tick=%0d code=4", t, bus.code, exp_t);
                end
                hits++;
                exp_t += 9;
            end
        end
        checks++;
        if (hits !== exp_hits) begin errors++; $display("FAIL repeat_count: got %0d expected %0d", hits, exp_hits); end
        S_n = 10'h3FF;
        tick(10);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        xfer = 0;
        rst = 1'b1;
        S_n = 10'h3FF;
        bus.ready = 1'b1;
        test_reset();
        test_single_press();
        test_priority();
        test_bounce();
        test_back_pressure();
        test_mid_reset();
        test_repeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
